// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: opcodes, FSM states, flag indices.
// Imported by the seq_alu top and used by the bench.
package seq_alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_NOT = 5'd5;
  localparam logic [4:0] OP_SHR = 5'd6;
  localparam logic [4:0] OP_ROR = 5'd7;
  localparam logic [4:0] OP_MAX = 5'd8;
  localparam logic [4:0] OP_MIN = 5'd9;
  localparam logic [4:0] OP_ABS = 5'd10;
  localparam logic [4:0] OP_MUL = 5'd11;
  localparam logic [4:0] OP_DIV = 5'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DIV  = 2'd3
  } state_e;

  localparam int F_N    = 0;
  localparam int F_Z    = 1;
  localparam int F_O    = 2;
  localparam int F_E    = 3;
  localparam int F_CO   = 4;
  localparam int NFLAGS = 5;

endpackage

// File: rtl/seq_alu_shifter.sv
// seq_alu_shifter: combinational right shift with fill bit,
// or right rotate, by an SHW-bit run-time amount.
module seq_alu_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amt,
  input  logic             fill,
  input  logic             rot,
  output logic [WIDTH-1:0] y
);

  logic [2*WIDTH-1:0] ext;

  // Upper half supplies the bits shifted in: a copy of a or the fill.
  always_comb begin
    ext = rot ? {a, a} : {{WIDTH{fill}}, a};
    y   = WIDTH'(ext >> amt);
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered multi-cycle ALU with start/done handshake.
// SEQ_ALU_DIV_EN adds op 12 as iterative unsigned division.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             si,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             n,
  output logic             z,
  output logic             o,
  output logic             e,
  output logic             co
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_e state_q, state_d;
  logic [4:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic si_q, si_d;
  logic ci_q, ci_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] r_hi_q, r_hi_d;
  logic [NFLAGS-1:0] flags_q, flags_d;

  logic [WIDTH-1:0] sh_y;
  logic [WIDTH:0] add_s;
  logic [WIDTH:0] sub_s;
  logic [WIDTH-1:0] ex_r;
  logic [NFLAGS-1:0] ex_f;
  logic ex_known;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0] div_sh;
  logic div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic div_zero;
`endif

  seq_alu_shifter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shifter (
    .a    (a_q),
    .amt  (b_q[SHW-1:0]),
    .fill (si_q),
    .rot  (op_q == OP_ROR),
    .y    (sh_y)
  );

  // Single-cycle result and flags from the captured operands.
  always_comb begin
    ex_r     = '0;
    ex_f     = '0;
    ex_known = 1'b1;
    add_s = {1'b0, a_q} + {1'b0, b_q}
          + {{WIDTH{1'b0}}, ci_q};
    sub_s = {1'b0, a_q} - {1'b0, b_q};
    case (op_q)
      OP_ADD: begin
        ex_r        = add_s[WIDTH-1:0];
        ex_f[F_CO]  = add_s[WIDTH];
        ex_f[F_O]   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                   && (add_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        ex_r        = sub_s[WIDTH-1:0];
        ex_f[F_CO]  = sub_s[WIDTH];
        ex_f[F_O]   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                   && (sub_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: ex_r = a_q & b_q;
      OP_OR:  ex_r = a_q | b_q;
      OP_XOR: ex_r = a_q ^ b_q;
      OP_NOT: ex_r = ~a_q;
      OP_SHR: ex_r = sh_y;
      OP_ROR: ex_r = sh_y;
      OP_MAX: ex_r = ($signed(a_q) > $signed(b_q)) ? a_q : b_q;
      OP_MIN: ex_r = ($signed(a_q) < $signed(b_q)) ? a_q : b_q;
      OP_ABS: begin
        ex_r      = a_q[WIDTH-1] ? -a_q : a_q;
        ex_f[F_O] = (a_q == MOST_NEG);
      end
      default: ex_known = 1'b0;
    endcase
    if (ex_known) begin
      ex_f[F_N] = ex_r[WIDTH-1];
      ex_f[F_Z] = (ex_r == '0);
      ex_f[F_E] = (a_q == b_q);
    end
  end

  // One shift-add step on {acc, multiplier}; multiplicand is b.
  always_comb begin
    mul_sum = {1'b0, acc_q}
            + (mq_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    prod_hi = mul_sum[WIDTH:1];
    prod_lo = {mul_sum[0], mq_q[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  // One restoring-division step: remainder in acc, quotient in mq.
  always_comb begin
    div_sh   = {acc_q, mq_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_rem  = div_ge ? WIDTH'(div_sh - {1'b0, b_q})
                      : div_sh[WIDTH-1:0];
    div_quo  = {mq_q[WIDTH-2:0], div_ge};
    div_zero = (b_q == '0);
  end
`endif

  // Handshake FSM and output register next-state.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    si_d    = si_q;
    ci_d    = ci_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    r_d     = r_q;
    r_hi_d  = r_hi_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op;
          a_d    = a;
          b_d    = b;
          si_d   = si;
          ci_d   = ci;
          acc_d  = '0;
          mq_d   = a;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (op == OP_MUL) begin
            state_d = ST_MUL;
`ifdef SEQ_ALU_DIV_EN
          end else if (op == OP_DIV) begin
            state_d = ST_DIV;
`endif
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        r_d     = ex_r;
        r_hi_d  = '0;
        flags_d = ex_f;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_MUL: begin
        acc_d = prod_hi;
        mq_d  = prod_lo;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          r_d           = prod_lo;
          r_hi_d        = prod_hi;
          flags_d       = '0;
          flags_d[F_N]  = prod_hi[WIDTH-1];
          flags_d[F_Z]  = ({prod_hi, prod_lo} == '0);
          flags_d[F_E]  = (a_q == b_q);
          done_d        = 1'b1;
          busy_d        = 1'b0;
          state_d       = ST_IDLE;
        end
      end
`ifdef SEQ_ALU_DIV_EN
      ST_DIV: begin
        acc_d = div_rem;
        mq_d  = div_quo;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          r_d           = div_zero ? '1 : div_quo;
          r_hi_d        = div_zero ? a_q : div_rem;
          flags_d       = '0;
          flags_d[F_N]  = r_d[WIDTH-1];
          flags_d[F_Z]  = (r_d == '0);
          flags_d[F_O]  = div_zero;
          flags_d[F_E]  = (a_q == b_q);
          done_d        = 1'b1;
          busy_d        = 1'b0;
          state_d       = ST_IDLE;
        end
      end
`endif
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured operands and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      si_q    <= 1'b0;
      ci_q    <= 1'b0;
      acc_q   <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      r_hi_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      si_q    <= si_d;
      ci_q    <= ci_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
      r_hi_q  <= r_hi_d;
      flags_q <= flags_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;
  assign r_hi = r_hi_q;
  assign n    = flags_q[F_N];
  assign z    = flags_q[F_Z];
  assign o    = flags_q[F_O];
  assign e    = flags_q[F_E];
  assign co   = flags_q[F_CO];

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered, multi-cycle ALU; successor of the team's 8-bit combinational ALU.
- Operand width is set by a parameter. Operands are captured on a start/done handshake. Shifts and rotates take a run-time amount.
- Multiply is iterative shift-add with a full double-width product. Result and flags are held in output registers until the next operation.
- Sits between the register file and the writeback mux of the datapath; the controller waits on done.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  5  operation code, captured with start
- a  in  WIDTH  operand A, signed
- b  in  WIDTH  operand B, signed; shift amount in b[SHW-1:0]
- si  in  1  serial fill bit for SHR
- ci  in  1  carry-in for ADD
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: r, r_hi and flags are valid
- r  out  WIDTH  result (low half for MUL)
- r_hi  out  WIDTH  high half of the MUL product; 0 for all other ops
- n, z, o, e, co  out  1 each  negative, zero, signed overflow, a==b, carry/borrow

Behaviour:
- Clock and reset: one clock domain; rst is asynchronous and active-high.
- Reset values: busy=0, done=0, r=0, r_hi=0, all flags 0, FSM in IDLE.
- FSM states:
  - IDLE: on start, capture op/a/b/si/ci into internal registers. Go to EXEC, or to MUL if op=MUL. Raise busy next edge.
  - EXEC: compute and register r/flags, pulse done, drop busy, go to IDLE. Latency is 2 edges from the start edge (done high in the cycle after EXEC).
  - MUL: WIDTH iterations of unsigned shift-add on {acc, multiplier}, with an internal counter from 0 to WIDTH-1. On the last count, register the product, pulse done and go to IDLE. Latency is WIDTH+1 cycles after start.
- start while busy=1 is ignored; no queueing.
- start in the same cycle done is pulsed is accepted, giving back-to-back operation.
- Outputs r, r_hi and flags hold until the next done; they do not change during busy.
- Opcodes and results (width-truncated):
  - 0 ADD: a+b+ci
  - 1 SUB: a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~a
  - 6 SHR: a shifted right by the shift amount, filled with si
  - 7 ROR: a rotated right by the shift amount
  - 8 MAX: signed
  - 9 MIN: signed
  - 10 ABS
  - 11 MUL: unsigned a*b, 2*WIDTH bits into {r_hi,r}
  - 12 DIV: optional
  - any other code: r=0, r_hi=0, all flags 0, done after normal EXEC latency
- Shift amount 0 gives r=a for SHR and ROR.
- Flag rules:
  - n = MSB of r; for MUL, n = MSB of r_hi.
  - z = 1 when r==0; for MUL, z requires {r_hi,r}==0.
  - e = (a==b) of the captured operands, for all ops.
  - co = carry out of bit WIDTH-1 for ADD; borrow (a<b unsigned) for SUB; else 0.
  - o = signed overflow for ADD/SUB by sign rule; for ABS of the most-negative value, r=that value and o=1; else 0.
- Reset asserted mid-MUL: aborts immediately to reset values; no done pulse.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- Defined: op 12 DIV is unsigned restoring division in WIDTH iterations (DIV state, shares the MUL counter). r=quotient, r_hi=remainder, latency WIDTH+1.
  - Divide by zero: r = all ones, r_hi=a, o=1.
- Undefined: op 12 behaves as an unknown opcode; no divider logic is present.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode localparams OP_ADD..OP_DIV
  - FSM state encoding (IDLE, EXEC, MUL, DIV)
  - flag bit-index constants
- Sub-module seq_alu_shifter: combinational right shift/rotate by SHW-bit amount with fill bit, parametrised by WIDTH; instantiated once in EXEC logic.

Test Plan (WIDTH=8):
- ADD overflow: a=0x7F, b=0x01, ci=0 -> r=0x80, n=1, o=1, co=0, z=0; done exactly 2 cycles after start.
- SUB borrow: a=0x03, b=0x05 -> r=0xFE, co=1, n=1, o=0; a=b=0x42 -> r=0, z=1, e=1.
- SHR/ROR: a=0xB4, b=3, si=1 -> SHR r=0xF6; ROR r=0x96; b=0 -> r=0xB4 for both.
- MUL: a=0xFF, b=0xFF -> {r_hi,r}=0xFE01, done 9 cycles after start, busy high throughout; start pulsed mid-MUL is ignored.
- ABS/MAX/MIN signed: a=0x80 -> ABS r=0x80, o=1; a=0xF0, b=0x10 -> MAX 0x10, MIN 0xF0; op=31 -> r=0, all flags 0.
- Reset and divide: rst asserted at MUL iteration 4 -> busy=0, outputs 0, no done, then a new ADD completes normally. With SEQ_ALU_DIV_EN: a=200, b=7 -> r=28, r_hi=4; b=0 -> r=0xFF, r_hi=200, o=1.
